// File: rtl/memaccess_if.sv
// memaccess_if: groups the access-request and data-memory bus signals of memaccess_ctrl.
interface memaccess_if;
   logic        start;
   logic [1:0]  mem_op;
   logic [15:0] M_addr;
   logic [15:0] M_data;
   logic [15:0] DMem_dout;
   logic [15:0] DMem_addr;
   logic [15:0] DMem_din;
   logic        DMem_rd;
   logic [15:0] memout;
   logic [1:0]  mem_state;
   logic        busy;
   logic        done;
   modport slave (
      input  start, mem_op, M_addr, M_data, DMem_dout,
      output DMem_addr, DMem_din, DMem_rd, memout, mem_state, busy, done
   );
   modport master (
      output start, mem_op, M_addr, M_data, DMem_dout,
      input  DMem_addr, DMem_din, DMem_rd, memout, mem_state, busy, done
   );
endinterface

// File: rtl/memaccess_ctrl.sv
// memaccess_ctrl: sequences direct/indirect loads and stores against a combinational-read data memory.
module memaccess_ctrl #(
   parameter logic [15:0] IDLE_ADDR = 16'h0000
) (
   input logic         clock,
   input logic         reset,
   memaccess_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE     = 2'b11,
      INDIRECT = 2'b01,
      READ     = 2'b00,
      WRITE    = 2'b10
   } state_t;
   state_t      state;
   logic [15:0] addr_q;
   logic [15:0] data_q;
   logic [1:0]  op_q;
   logic [15:0] memout_q;
   logic        done_q;
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         addr_q   <= 16'h0000;
         data_q   <= 16'h0000;
         op_q     <= 2'b00;
         memout_q <= 16'h0000;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               addr_q <= bus.M_addr;
               data_q <= bus.M_data;
               op_q   <= bus.mem_op;
               state  <= bus.mem_op[0] ? INDIRECT : (bus.mem_op[1] ? WRITE : READ);
            end
            INDIRECT: begin
               addr_q <= bus.DMem_dout;
               // op_q[0] is always set here, so this is a test of the store bit
               state  <= (op_q == 2'b11) ? WRITE : READ;
            end
            READ: begin
               memout_q <= bus.DMem_dout;
               done_q   <= 1'b1;
               state    <= IDLE;
            end
            default: begin
               done_q <= 1'b1;
               state  <= IDLE;
            end
         endcase
      end
   end
   assign bus.mem_state = state;
   assign bus.busy      = (state != IDLE);
   assign bus.done      = done_q;
   assign bus.memout    = memout_q;
   assign bus.DMem_addr = (state == IDLE) ? IDLE_ADDR : addr_q;
   assign bus.DMem_din  = (state == WRITE) ? data_q : 16'h0000;
   // reset overrides so a store caught mid-flight never commits
   assign bus.DMem_rd   = reset | (state != WRITE);
endmodule

// File: tb/tb_memaccess_ctrl.sv
// tb_memaccess_ctrl: directed checks of memaccess_ctrl against a behavioral data memory.
module tb_memaccess_ctrl;
   localparam logic [15:0] IDLE_A = 16'hDEAD;
   logic clock;
   logic reset;
   int checks;
   int failures;
   int lows;
   int dones;
   logic [15:0] mem [0:65535];
   memaccess_if bus ();
   memaccess_ctrl #(.IDLE_ADDR(IDLE_A)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );
   assign bus.DMem_dout = mem[bus.DMem_addr];
   always @(posedge clock) if (!bus.DMem_rd) mem[bus.DMem_addr] <= bus.DMem_din;
   initial clock = 1'b0;
   always #5 clock = ~clock;
   task automatic step;
      @(posedge clock);
      #1;
   endtask
   task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d);
      bus.start = 1'b1; bus.mem_op = op; bus.M_addr = a; bus.M_data = d;
   endtask
   task automatic test_reset;
      reset = 1'b1; bus.start = 1'b0; bus.mem_op = 2'b00; bus.M_addr = 16'h0; bus.M_data = 16'h0;
      step; step;
      reset = 1'b0;
      #1;
      checks++; if (bus.mem_state !== 2'b11) begin failures++; $display("FAIL reset_state got=%b exp=11", bus.mem_state); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.DMem_addr !== IDLE_A) begin failures++; $display("FAIL reset_addr got=%h exp=%h", bus.DMem_addr, IDLE_A); end
      checks++; if (bus.memout !== 16'h0) begin failures++; $display("FAIL reset_memout got=%h exp=0000", bus.memout); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      checks++; if ({bus.DMem_rd, bus.DMem_din} !== {1'b1, 16'h0}) begin failures++; $display("FAIL reset_rd_din got=%b/%h exp=1/0000", bus.DMem_rd, bus.DMem_din); end
   endtask
   task automatic test_direct_load;
      mem[16'h3000] <= 16'hBEEF;
      issue(2'b00, 16'h3000, 16'h0);
      step;
      bus.start = 1'b0;
      checks++; if (bus.mem_state !== 2'b00) begin failures++; $display("FAIL dload_state got=%b exp=00", bus.mem_state); end
      checks++; if ({bus.DMem_addr, bus.DMem_rd, bus.busy} !== {16'h3000, 1'b1, 1'b1}) begin failures++; $display("FAIL dload_bus got=%h/%b/%b exp=3000/1/1", bus.DMem_addr, bus.DMem_rd, bus.busy); end
      step;
      checks++; if ({bus.mem_state, bus.done} !== {2'b11, 1'b1}) begin failures++; $display("FAIL dload_done got=%b/%b exp=11/1", bus.mem_state, bus.done); end
      checks++; if (bus.memout !== 16'hBEEF) begin failures++; $display("FAIL dload_memout got=%h exp=beef", bus.memout); end
      step;
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL dload_pulse got=%b exp=0", bus.done); end
   endtask
   task automatic test_indirect_load;
      mem[16'h3010] <= 16'h4000;
      mem[16'h4000] <= 16'h1234;
      issue(2'b01, 16'h3010, 16'h0);
      step;
      bus.start = 1'b0;
      checks++; if ({bus.mem_state, bus.DMem_addr, bus.DMem_din} !== {2'b01, 16'h3010, 16'h0}) begin failures++; $display("FAIL iload_c1 got=%b/%h/%h exp=01/3010/0000", bus.mem_state, bus.DMem_addr, bus.DMem_din); end
      step;
      checks++; if ({bus.mem_state, bus.DMem_addr} !== {2'b00, 16'h4000}) begin failures++; $display("FAIL iload_c2 got=%b/%h exp=00/4000", bus.mem_state, bus.DMem_addr); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL iload_early_done got=%b exp=0", bus.done); end
      step;
      checks++; if ({bus.mem_state, bus.done, bus.memout} !== {2'b11, 1'b1, 16'h1234}) begin failures++; $display("FAIL iload_c3 got=%b/%b/%h exp=11/1/1234", bus.mem_state, bus.done, bus.memout); end
      step;
   endtask
   task automatic test_indirect_store;
      mem[16'h3020] <= 16'h5000;
      mem[16'h5000] <= 16'h0000;
      lows = 0;
      issue(2'b11, 16'h3020, 16'hA5A5);
      step;
      bus.start = 1'b0;
      if (!bus.DMem_rd) lows++;
      checks++; if (bus.mem_state !== 2'b01) begin failures++; $display("FAIL istore_c1 got=%b exp=01", bus.mem_state); end
      step;
      if (!bus.DMem_rd) lows++;
      checks++; if ({bus.mem_state, bus.DMem_addr, bus.DMem_din, bus.DMem_rd} !== {2'b10, 16'h5000, 16'hA5A5, 1'b0}) begin failures++; $display("FAIL istore_c2 got=%b/%h/%h/%b exp=10/5000/a5a5/0", bus.mem_state, bus.DMem_addr, bus.DMem_din, bus.DMem_rd); end
      step;
      if (!bus.DMem_rd) lows++;
      checks++; if ({bus.done, bus.memout} !== {1'b1, 16'h1234}) begin failures++; $display("FAIL istore_done got=%b/%h exp=1/1234", bus.done, bus.memout); end
      checks++; if (mem[16'h5000] !== 16'hA5A5) begin failures++; $display("FAIL istore_mem got=%h exp=a5a5", mem[16'h5000]); end
      step;
      if (!bus.DMem_rd) lows++;
      checks++; if (lows !== 1) begin failures++; $display("FAIL istore_wr_cycles got=%0d exp=1", lows); end
   endtask
   task automatic test_busy_ignore;
      mem[16'h6000] <= 16'h0000;
      dones = 0;
      issue(2'b01, 16'h3010, 16'h0);
      step;
      issue(2'b10, 16'h6000, 16'hFFFF);
      step;
      bus.start = 1'b0;
      dones += int'(bus.done);
      checks++; if ({bus.mem_state, bus.DMem_addr} !== {2'b00, 16'h4000}) begin failures++; $display("FAIL busy_state got=%b/%h exp=00/4000", bus.mem_state, bus.DMem_addr); end
      step;
      dones += int'(bus.done);
      step;
      dones += int'(bus.done);
      step;
      dones += int'(bus.done);
      checks++; if (dones !== 1) begin failures++; $display("FAIL busy_done_count got=%0d exp=1", dones); end
      checks++; if ({bus.mem_state, mem[16'h6000]} !== {2'b11, 16'h0000}) begin failures++; $display("FAIL busy_no_queue got=%b/%h exp=11/0000", bus.mem_state, mem[16'h6000]); end
   endtask
   task automatic test_back_to_back;
      issue(2'b00, 16'h3000, 16'h0);
      step;
      bus.start = 1'b0;
      step;
      checks++; if ({bus.done, bus.memout} !== {1'b1, 16'hBEEF}) begin failures++; $display("FAIL b2b_load got=%b/%h exp=1/beef", bus.done, bus.memout); end
      issue(2'b10, 16'hFFFF, 16'h1111);
      step;
      bus.start = 1'b0;
      checks++; if ({bus.mem_state, bus.DMem_addr, bus.DMem_rd} !== {2'b10, 16'hFFFF, 1'b0}) begin failures++; $display("FAIL b2b_write got=%b/%h/%b exp=10/ffff/0", bus.mem_state, bus.DMem_addr, bus.DMem_rd); end
      step;
      checks++; if ({bus.done, bus.memout, mem[16'hFFFF]} !== {1'b1, 16'hBEEF, 16'h1111}) begin failures++; $display("FAIL b2b_store got=%b/%h/%h exp=1/beef/1111", bus.done, bus.memout, mem[16'hFFFF]); end
      step;
   endtask
   task automatic test_reset_in_write;
      mem[16'h0000] <= 16'h0000;
      issue(2'b10, 16'h0000, 16'h7777);
      step;
      bus.start = 1'b0;
      checks++; if ({bus.mem_state, bus.DMem_rd} !== {2'b10, 1'b0}) begin failures++; $display("FAIL rstw_pre got=%b/%b exp=10/0", bus.mem_state, bus.DMem_rd); end
      reset = 1'b1;
      #1;
      checks++; if (bus.DMem_rd !== 1'b1) begin failures++; $display("FAIL rstw_rd got=%b exp=1", bus.DMem_rd); end
      step;
      reset = 1'b0;
      #1;
      checks++; if (mem[16'h0000] !== 16'h0000) begin failures++; $display("FAIL rstw_mem got=%h exp=0000", mem[16'h0000]); end
      checks++; if ({bus.mem_state, bus.memout, bus.done, bus.busy} !== {2'b11, 16'h0, 1'b0, 1'b0}) begin failures++; $display("FAIL rstw_after got=%b/%h/%b/%b exp=11/0000/0/0", bus.mem_state, bus.memout, bus.done, bus.busy); end
      step;
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rstw_no_done got=%b exp=0", bus.done); end
   endtask
   initial begin
      checks = 0;
      failures = 0;
      test_reset;
      test_direct_load;
      test_indirect_load;
      test_indirect_store;
      test_busy_ignore;
      test_back_to_back;
      test_reset_in_write;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/memaccess_ctrl.md
MEMACCESS_CTRL -- requirements
Module: memaccess_ctrl

Interface
REQ-001 SHALL have parameter IDLE_ADDR, default 16'h0000, the DMem_addr value driven when no access is in progress.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin one access; sampled only in IDLE.
REQ-005 SHALL have port mem_op, input, 2, access type: 00 load direct, 01 load indirect, 10 store direct, 11 store indirect.
REQ-006 SHALL have port M_addr, input, 16, effective (direct) or pointer (indirect) address.
REQ-007 SHALL have port M_data, input, 16, store data.
REQ-008 SHALL have port DMem_dout, input, 16, data memory read data, combinationally valid for the current DMem_addr.
REQ-009 SHALL have port DMem_addr, output, 16, data memory address.
REQ-010 SHALL have port DMem_din, output, 16, data memory write data.
REQ-011 SHALL have port DMem_rd, output, 1, 1 = read, 0 = write committed at the next rising edge.
REQ-012 SHALL have port memout, output, 16, last completed load data.
REQ-013 SHALL have port mem_state, output, 2, current FSM state encoding.
REQ-014 SHALL have port busy, output, 1, high in any non-IDLE state.
REQ-015 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE=2'b11, INDIRECT=2'b01, READ=2'b00 and WRITE=2'b10, with mem_state equal to the state register.
REQ-017 SHALL, in IDLE with start=1, latch M_addr into addr_q, M_data into data_q and mem_op into op_q, then go to INDIRECT if mem_op[0]=1, else READ if mem_op[1]=0, else WRITE.
REQ-018 SHALL ignore start whenever the state is not IDLE, with no queuing.
REQ-019 SHALL, in INDIRECT, drive DMem_addr=addr_q and DMem_rd=1, load addr_q<=DMem_dout at the edge, and go to READ if op_q[1]=0, else WRITE.
REQ-020 SHALL, in READ, drive DMem_addr=addr_q and DMem_rd=1, load memout<=DMem_dout at the edge, and go to IDLE.
REQ-021 SHALL, in WRITE, drive DMem_addr=addr_q, DMem_din=data_q and DMem_rd=0, and go to IDLE.
REQ-022 SHALL, in IDLE and INDIRECT, drive DMem_din=16'h0000; in IDLE it SHALL also drive DMem_addr=IDLE_ADDR and DMem_rd=1.
REQ-023 SHALL register done high for exactly the one IDLE cycle following a READ or WRITE, and low otherwise.
REQ-024 SHALL accept a start in the same cycle that done is high, allowing back-to-back operations.
REQ-025 SHALL complete operations with the following start-edge-to-done latency: direct ops 2 cycles, indirect ops 3 cycles.
REQ-026 SHALL leave memout unchanged by stores and hold it until the next READ completes.
REQ-027 SHALL drive DMem_rd=0 only in the WRITE state, for exactly one cycle per store.
REQ-028 SHALL treat all addresses as plain 16-bit values, including 16'hFFFF and 16'h0000, with no wrap or range logic.

Reset
REQ-029 SHALL, on a rising edge with reset=1, set state=IDLE, addr_q=0, data_q=0, op_q=0, memout=16'h0000 and done=0.
REQ-030 SHALL combinationally force DMem_rd=1 while reset=1 so that no write commits during reset, including when reset is asserted in WRITE.
REQ-031 SHALL abandon any in-progress operation on reset, with no done pulse.
REQ-032 SHALL, after reset deasserts, drive mem_state=2'b11, busy=0 and DMem_addr=IDLE_ADDR.

Verification
REQ-033 SHALL verify a direct load: mem[16'h3000]=16'hBEEF, start with op=00 and M_addr=16'h3000 -> next cycle READ with DMem_addr=16'h3000 and DMem_rd=1; cycle after that done=1 and memout=16'hBEEF.
REQ-034 SHALL verify an indirect load: mem[16'h3010]=16'h4000 and mem[16'h4000]=16'h1234, op=01 and M_addr=16'h3010 -> mem_state sequence 01, 00, 11; DMem_addr sequence 16'h3010, 16'h4000; done at the third cycle with memout=16'h1234.
REQ-035 SHALL verify an indirect store: mem[16'h3020]=16'h5000, op=11, M_addr=16'h3020 and M_data=16'hA5A5 -> exactly one DMem_rd=0 cycle, with DMem_addr=16'h5000 and DMem_din=16'hA5A5; memout unchanged.
REQ-036 SHALL verify that start is ignored while busy: a second start during INDIRECT has no effect, and only one done pulse occurs.
REQ-037 SHALL verify back-to-back operation: a store issued in the done cycle of a load -> WRITE in the next cycle and no idle gap.
REQ-038 SHALL verify reset in WRITE: DMem_rd=1 during the reset cycle, the target location is unmodified, and the next state is IDLE with memout=0 and done=0.
